// File: rtl/dd2_sub_pkg.sv
// Shared definitions for the Double Dragon 2 sub-CPU bus controller:
// decoded memory regions, open-bus value and the address decoder helper.
package dd2_sub_pkg;

    typedef enum logic [2:0] {
        REG_SHARED  = 3'b000,
        REG_NMIACK  = 3'b001,
        REG_IRQMAIN = 3'b010,
        REG_NONE    = 3'b011,
        REG_ROM     = 3'b100
    } region_e;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

    // 0000-BFFF is ROM; the top 16 KB page is split into 4 KB I/O windows
    function automatic region_e decode_region(input logic [15:0] addr);
        region_e r;
        if (addr[15:14] != 2'b11) begin
            r = REG_ROM;
        end else begin
            case (addr[13:12])
                2'b00:   r = REG_SHARED;
                2'b01:   r = REG_NMIACK;
                2'b10:   r = REG_IRQMAIN;
                default: r = REG_NONE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/dd2_sub_bus_ctrl_dpram.sv
// True dual-port byte RAM with registered reads on both ports.
// Port A (sub CPU) wins over port B (main CPU) on a same-address write.
module dd2_dpram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [7:0]    a_din,
    output logic [7:0]    a_q,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [7:0]    b_din,
    output logic [7:0]    b_q
);
    import dd2_sub_pkg::*;

    logic [7:0] r_mem [0:(1<<AW)-1];
    logic [7:0] r_a_q;
    logic [7:0] r_b_q;

    // Storage write; port A is applied last so it overrides port B
    always_ff @(posedge clk) begin
        if (b_we) begin
            r_mem[b_addr] <= b_din;
        end
        if (a_we) begin
            r_mem[a_addr] <= a_din;
        end
    end

    // Registered read data, cleared by reset (array contents are not)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a_q <= 8'h00;
            r_b_q <= 8'h00;
        end else begin
            r_a_q <= r_mem[a_addr];
            r_b_q <= r_mem[b_addr];
        end
    end

    assign a_q = r_a_q;
    assign b_q = r_b_q;

endmodule

// File: rtl/dd2_sub_bus_ctrl.sv
// Bus glue for the DD2 sound/sub Z80: address decode, ROM wait states,
// shared RAM, NMI latch and bus-request handshake.
// Optional macro DD2_SHARED_WR_GATE_EN: main-CPU RAM writes only while the sub bus is granted.
module dd2_sub_bus_ctrl #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cen4,
    input  logic [AW-1:0] main_AB,
    input  logic          main_wrn,
    input  logic [7:0]    main_dout,
    output logic [7:0]    shared_dout,
    input  logic          com_cs,
    input  logic          mcu_halt,
    input  logic          mcu_nmi_set,
    output logic          mcu_ban,
    output logic          mcu_irqmain,
    output logic [15:0]   rom_addr,
    input  logic [7:0]    rom_data,
    output logic          rom_cs,
    input  logic          rom_ok,
    input  logic [15:0]   cpu_addr,
    input  logic          cpu_mreq_n,
    input  logic          cpu_wr_n,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_busak_n,
    output logic [7:0]    cpu_din,
    output logic          cpu_nmi_n,
    output logic          cpu_busrq_n,
    output logic          cpu_cen
);
    import dd2_sub_pkg::*;

    region_e    w_region;
    logic       w_rom_cs;
    logic       w_shared_cs;
    logic       w_nmi_ack;
    logic       w_irqmain;
    logic       w_sub_we;
    logic       w_main_we;
    logic [7:0] w_sub_q;
    logic [7:0] w_main_q;
    logic [7:0] w_cpu_din;
    logic       r_nmi_last;
    logic       r_nmi_q;

    // Memory-map decoder; every strobe is idle without MREQ
    always_comb begin
        w_rom_cs    = 1'b0;
        w_shared_cs = 1'b0;
        w_nmi_ack   = 1'b0;
        w_irqmain   = 1'b0;
        w_region    = decode_region(cpu_addr);
        if (!cpu_mreq_n) begin
            case (w_region)
                REG_ROM:     w_rom_cs    = 1'b1;
                REG_SHARED:  w_shared_cs = 1'b1;
                REG_NMIACK:  w_nmi_ack   = ~cpu_wr_n;
                REG_IRQMAIN: w_irqmain   = ~cpu_wr_n;
                default:     w_rom_cs    = 1'b0;
            endcase
        end else begin
            w_rom_cs = 1'b0;
        end
    end

    // Z80 read-data mux, ROM first, then shared RAM, else open bus
    always_comb begin
        w_cpu_din = OPEN_BUS;
        if (w_rom_cs) begin
            w_cpu_din = rom_data;
        end else if (w_shared_cs) begin
            w_cpu_din = w_sub_q;
        end else begin
            w_cpu_din = OPEN_BUS;
        end
    end

    assign w_sub_we = ~cpu_wr_n & w_shared_cs;
`ifdef DD2_SHARED_WR_GATE_EN
    assign w_main_we = ~main_wrn & com_cs & ~cpu_busak_n;
`else
    assign w_main_we = ~main_wrn & com_cs;
`endif

    dd2_dpram #(.AW(AW)) u_dpram (
        .clk    (clk),
        .rstn   (rstn),
        .a_addr (cpu_addr[AW-1:0]),
        .a_we   (w_sub_we),
        .a_din  (cpu_dout),
        .a_q    (w_sub_q),
        .b_addr (main_AB),
        .b_we   (w_main_we),
        .b_din  (main_dout),
        .b_q    (w_main_q)
    );

    // NMI latch: set on a rising edge of mcu_nmi_set, acknowledge clears first
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_nmi_last <= 1'b0;
            r_nmi_q    <= 1'b0;
        end else begin
            r_nmi_last <= mcu_nmi_set;
            if (w_nmi_ack) begin
                r_nmi_q <= 1'b0;
            end else if (mcu_nmi_set && !r_nmi_last) begin
                r_nmi_q <= 1'b1;
            end else begin
                r_nmi_q <= r_nmi_q;
            end
        end
    end

    assign cpu_cen     = cen4 & ~(w_rom_cs & ~rom_ok);
    assign cpu_din     = w_cpu_din;
    assign rom_cs      = w_rom_cs;
    assign rom_addr    = cpu_addr;
    assign mcu_irqmain = w_irqmain;
    assign shared_dout = w_main_q;
    assign cpu_nmi_n   = ~r_nmi_q;
    assign cpu_busrq_n = ~mcu_halt;
    assign mcu_ban     = cpu_busak_n;

endmodule

// File: tb/tb_dd2_sub_bus_ctrl.sv
// Scoreboard bench for dd2_sub_bus_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dd2_sub_bus_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cen4;
    logic [9:0]  main_AB;
    logic        main_wrn;
    logic [7:0]  main_dout;
    logic [7:0]  shared_dout;
    logic        com_cs;
    logic        mcu_halt;
    logic        mcu_nmi_set;
    logic        mcu_ban;
    logic        mcu_irqmain;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_cs;
    logic        rom_ok;
    logic [15:0] cpu_addr;
    logic        cpu_mreq_n;
    logic        cpu_wr_n;
    logic [7:0]  cpu_dout;
    logic        cpu_busak_n;
    logic [7:0]  cpu_din;
    logic        cpu_nmi_n;
    logic        cpu_busrq_n;
    logic        cpu_cen;

    localparam int S_DIN = 0, S_CEN = 1, S_ROMCS = 2, S_SHOUT = 3, S_NMIN = 4,
                   S_IRQ = 5, S_BUSRQ = 6, S_BAN = 7, S_ROMADDR = 8;

    typedef struct {
        int          sig;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dd2_sub_bus_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .cen4        (cen4),
        .main_AB     (main_AB),
        .main_wrn    (main_wrn),
        .main_dout   (main_dout),
        .shared_dout (shared_dout),
        .com_cs      (com_cs),
        .mcu_halt    (mcu_halt),
        .mcu_nmi_set (mcu_nmi_set),
        .mcu_ban     (mcu_ban),
        .mcu_irqmain (mcu_irqmain),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rom_cs      (rom_cs),
        .rom_ok      (rom_ok),
        .cpu_addr    (cpu_addr),
        .cpu_mreq_n  (cpu_mreq_n),
        .cpu_wr_n    (cpu_wr_n),
        .cpu_dout    (cpu_dout),
        .cpu_busak_n (cpu_busak_n),
        .cpu_din     (cpu_din),
        .cpu_nmi_n   (cpu_nmi_n),
        .cpu_busrq_n (cpu_busrq_n),
        .cpu_cen     (cpu_cen)
    );

    function automatic logic [15:0] probe(input int sig);
        logic [15:0] v;
        case (sig)
            S_DIN:     v = {8'h00, cpu_din};
            S_CEN:     v = {15'h0, cpu_cen};
            S_ROMCS:   v = {15'h0, rom_cs};
            S_SHOUT:   v = {8'h00, shared_dout};
            S_NMIN:    v = {15'h0, cpu_nmi_n};
            S_IRQ:     v = {15'h0, mcu_irqmain};
            S_BUSRQ:   v = {15'h0, cpu_busrq_n};
            S_BAN:     v = {15'h0, mcu_ban};
            S_ROMADDR: v = rom_addr;
            default:   v = 16'hxxxx;
        endcase
        return v;
    endfunction

    task automatic expect_v(input int sig, input logic [15:0] exp, input string name);
        chk_t c;
        c.sig  = sig;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation on the falling edge
    always @(negedge clk) begin
        chk_t        c;
        logic [15:0] got;
        while (sb.size() > 0) begin
            c   = sb.pop_front();
            got = probe(c.sig);
            n_checks++;
            if (got !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h at %0t", c.name, got, c.exp, $time);
            end
        end
    end

    initial begin
        rstn = 1'b0; cen4 = 1'b1; main_AB = 10'h000; main_wrn = 1'b1; main_dout = 8'h00;
        com_cs = 1'b0; mcu_halt = 1'b0; mcu_nmi_set = 1'b0; rom_data = 8'h00; rom_ok = 1'b0;
        cpu_addr = 16'h0000; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1; cpu_dout = 8'h00;
        cpu_busak_n = 1'b1;
        step(); step();
        expect_v(S_NMIN, 16'h0001, "rst_nmi_n");
        expect_v(S_SHOUT, 16'h0000, "rst_shared_dout");
        expect_v(S_DIN, 16'h00FF, "rst_cpu_din");
        expect_v(S_ROMCS, 16'h0000, "rst_rom_cs");
        expect_v(S_BUSRQ, 16'h0001, "rst_busrq_n");
        step();
        rstn = 1'b1;
        step();

        // ROM read with wait states
        cpu_addr = 16'h1234; cpu_mreq_n = 1'b0; rom_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_v(S_ROMCS, 16'h0001, "rom_wait_cs");
            expect_v(S_CEN, 16'h0000, "rom_wait_cen");
            expect_v(S_ROMADDR, 16'h1234, "rom_addr");
            step();
        end
        rom_data = 8'h5A; rom_ok = 1'b1;
        expect_v(S_DIN, 16'h005A, "rom_data");
        expect_v(S_CEN, 16'h0001, "rom_ok_cen");
        step();
        cen4 = 1'b0;
        expect_v(S_CEN, 16'h0000, "rom_ok_cen4_low");
        step();
        cen4 = 1'b1;

        // Sub write 0x3C to C005, main read, sub mirror read at C405
        cpu_addr = 16'hC005; cpu_wr_n = 1'b0; cpu_dout = 8'h3C;
        expect_v(S_ROMCS, 16'h0000, "shared_not_rom");
        step();
        cpu_wr_n = 1'b1; cpu_mreq_n = 1'b1; main_AB = 10'h005;
        step();
        expect_v(S_SHOUT, 16'h003C, "main_read_c005");
        step();
        cpu_addr = 16'hC405; cpu_mreq_n = 1'b0;
        step();
        expect_v(S_DIN, 16'h003C, "sub_mirror_c405");
        step();

        // Main write 0xA7 to 3FF while the sub bus is not granted
        cpu_addr = 16'hC3FF; cpu_wr_n = 1'b0; cpu_dout = 8'h11;
        step();
        cpu_wr_n = 1'b1; cpu_mreq_n = 1'b1;
        main_AB = 10'h3FF; main_dout = 8'hA7; main_wrn = 1'b0; com_cs = 1'b1; cpu_busak_n = 1'b1;
        step();
        main_wrn = 1'b1; com_cs = 1'b0; cpu_mreq_n = 1'b0;
        step();
`ifdef DD2_SHARED_WR_GATE_EN
        expect_v(S_DIN, 16'h0011, "gated_main_wr_sub");
        expect_v(S_SHOUT, 16'h0011, "gated_main_wr_main");
        step();
        cpu_mreq_n = 1'b1; main_wrn = 1'b0; com_cs = 1'b1; cpu_busak_n = 1'b0;
        step();
        main_wrn = 1'b1; com_cs = 1'b0; cpu_busak_n = 1'b1; cpu_mreq_n = 1'b0;
        step();
        expect_v(S_DIN, 16'h00A7, "granted_main_wr");
`else
        expect_v(S_DIN, 16'h00A7, "main_wr_sub");
        expect_v(S_SHOUT, 16'h00A7, "main_wr_main");
`endif
        step();

        // Same-address collision: sub port wins
        cpu_addr = 16'hC010; cpu_wr_n = 1'b0; cpu_dout = 8'h66; cpu_mreq_n = 1'b0;
        main_AB = 10'h010; main_dout = 8'h99; main_wrn = 1'b0; com_cs = 1'b1; cpu_busak_n = 1'b0;
        step();
        cpu_wr_n = 1'b1; main_wrn = 1'b1; com_cs = 1'b0; cpu_busak_n = 1'b1;
        step();
        expect_v(S_DIN, 16'h0066, "collision_sub");
        expect_v(S_SHOUT, 16'h0066, "collision_main");
        step();

        // NMI edge, acknowledge, level held high
        cpu_mreq_n = 1'b1; mcu_nmi_set = 1'b1;
        step();
        expect_v(S_NMIN, 16'h0000, "nmi_set");
        step();
        cpu_addr = 16'hD000; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
        step();
        expect_v(S_NMIN, 16'h0001, "nmi_ack");
        step();
        cpu_wr_n = 1'b1; cpu_mreq_n = 1'b1;
        step(); step();
        expect_v(S_NMIN, 16'h0001, "nmi_level_held");
        step();

        // Acknowledge beats a simultaneous rising edge
        mcu_nmi_set = 1'b0;
        step();
        mcu_nmi_set = 1'b1; cpu_addr = 16'hD000; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
        step();
        expect_v(S_NMIN, 16'h0001, "nmi_ack_priority");
        step();
        cpu_wr_n = 1'b1; cpu_mreq_n = 1'b1;
        step();
        expect_v(S_NMIN, 16'h0001, "nmi_after_priority");
        step();

        // IRQ-to-main strobe and unmapped read
        cpu_addr = 16'hE000; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
        expect_v(S_IRQ, 16'h0001, "irqmain_write");
        step();
        cpu_wr_n = 1'b1;
        expect_v(S_IRQ, 16'h0000, "irqmain_read");
        step();
        cpu_addr = 16'hF000;
        expect_v(S_DIN, 16'h00FF, "open_bus_f000");
        expect_v(S_IRQ, 16'h0000, "f000_no_irq");
        expect_v(S_ROMCS, 16'h0000, "f000_no_rom");
        step();
        cpu_mreq_n = 1'b1;

        // Bus request handshake
        mcu_halt = 1'b1;
        expect_v(S_BUSRQ, 16'h0000, "busrq_asserted");
        step();
        cpu_busak_n = 1'b0;
        expect_v(S_BAN, 16'h0000, "ban_granted");
        step();
        mcu_halt = 1'b0; cpu_busak_n = 1'b1;
        expect_v(S_BUSRQ, 16'h0001, "busrq_released");
        expect_v(S_BAN, 16'h0001, "ban_released");
        step();

        // Asynchronous reset while NMI is pending
        mcu_nmi_set = 1'b0;
        step();
        mcu_nmi_set = 1'b1;
        step();
        expect_v(S_NMIN, 16'h0000, "nmi_before_reset");
        step();
        rstn = 1'b0;
        expect_v(S_NMIN, 16'h0001, "nmi_async_reset");
        expect_v(S_SHOUT, 16'h0000, "shared_dout_async_reset");
        step();
        mcu_nmi_set = 1'b0;
        step();
        rstn = 1'b1;
        step();

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
